uart_link_tester: RTL and testbench
===================================

Name: uart_link_tester

Overview:
- Parametrised self-checking UART link exerciser. Drives an existing `uart_tx` and monitors an existing `uart_rx`, normally looped back through board pins.
- Successor to the fixed incrementing-byte bring-up loop. Adds generic data width, selectable test patterns, bounded or continuous runs, rx timeout detection, and saturating error statistics.
- Sits in board-level tops used for link bring-up and bit-error characterisation. Counters are exposed for LEDs, GPIO probes or a later readout block.

Parameters:
- DATA_WIDTH, 8: payload width; must match uart_tx/uart_rx.
- COUNT_WIDTH, 16: width of every statistics counter.
- NUM_FRAMES, 0: frames per run; 0 = continuous until reset.
- RX_TIMEOUT, 364: clk cycles allowed after tx_busy falls for rx_done to arrive.
- GAP_CYCLES, 16: idle clk cycles between frames.
- LFSR_TAPS, 8'hB8: Galois LFSR feedback mask for PRBS mode, DATA_WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- mode  in  2  pattern: 0 increment, 1 PRBS, 2 walking-one, 3 fixed; sampled on accepted start.
- seed  in  DATA_WIDTH  first pattern word; sampled on accepted start.
- data_to_tx  out  DATA_WIDTH  word presented to uart_tx.
- start_tx  out  1  transmit request to uart_tx.
- tx_busy  in  1  uart_tx busy flag.
- data_received  in  DATA_WIDTH  uart_rx output word.
- rx_done  in  1  uart_rx one-cycle completion pulse.
- parity_error  in  1  uart_rx parity flag, valid with rx_done.
- running  out  1  high from accepted start until DONE or IDLE.
- done  out  1  high in DONE.
- error_pulse  out  1  one-cycle pulse per failed frame.
- frame_count  out  COUNT_WIDTH  frames completed.
- error_count  out  COUNT_WIDTH  data mismatches.
- parity_count  out  COUNT_WIDTH  frames with parity_error.
- timeout_count  out  COUNT_WIDTH  frames with no rx_done.

Behaviour:
- Reset: state IDLE. Outputs start_tx, running, done and error_pulse = 0. All counters = 0. data_to_tx = 0. rx_seen flag = 0.
- Reset mid-run aborts immediately to IDLE; no further start_tx.
- States: IDLE, TX_START, TX_WAIT, RX_WAIT, CHECK, UPDATE, GAP, DONE.
- IDLE/DONE + start:
  - Load pattern = seed. In PRBS mode a zero seed is replaced with 1.
  - Clear all counters, clear done, set running, go to TX_START.
- TX_START:
  - Hold start_tx = 1 and clear rx_seen on entry.
  - On tx_busy = 1, drop start_tx next cycle and go to TX_WAIT.
- TX_WAIT: on tx_busy = 0, zero the timeout counter and go to RX_WAIT.
- rx_done capture: from TX_START entry through RX_WAIT, any rx_done sets rx_seen and latches data_received and parity_error. rx_done may arrive before tx_busy falls.
- RX_WAIT:
  - If rx_seen, go to CHECK.
  - Otherwise increment the timeout counter. When it reaches RX_TIMEOUT, increment timeout_count, pulse error_pulse, and go to UPDATE.
- CHECK:
  - Latched word != data_to_tx: increment error_count.
  - Latched parity flag set: increment parity_count.
  - Either condition: error_pulse = 1 for exactly one cycle (one pulse even if both occur).
  - Then go to UPDATE.
- UPDATE:
  - frame_count++.
  - Advance the pattern:
    - increment: +1, wrapping all-ones to 0.
    - PRBS: Galois shift right; if the shifted-out LSB is 1, XOR with LFSR_TAPS.
    - walking-one: rotate left by 1.
    - fixed: unchanged.
  - If NUM_FRAMES != 0 and the new frame_count == NUM_FRAMES, go to DONE. Otherwise go to GAP.
- GAP: wait GAP_CYCLES cycles, then go to TX_START. GAP_CYCLES = 0 means straight to TX_START.
- DONE: running = 0, done = 1, counters hold. A new start restarts the run.
- Counters saturate at all-ones and never wrap. frame_count still terminates correctly when NUM_FRAMES < 2^COUNT_WIDTH.
- Extra rx_done outside the capture window is ignored and not counted.
- start while running is ignored.

Test Plan:
- Ideal loopback, mode 0, seed 8'hFE, NUM_FRAMES = 4 -> tx words FE, FF, 00, 01; frame_count = 4; error_count = parity_count = timeout_count = 0; done = 1.
- Mode 1, seed 0, NUM_FRAMES = 3, taps B8 -> tx words 01, B8, 5C; no errors.
- Rx model corrupts bit 0 of the 2nd frame only, NUM_FRAMES = 5 -> error_count = 1; exactly one error_pulse; frame_count = 5.
- Rx silent, RX_TIMEOUT = 10, NUM_FRAMES = 2 -> timeout_count = 2; error_pulse seen twice, each 10 cycles after tx_busy falls; done = 1.
- Rx returns mismatched data plus parity_error on frame 1 -> error_count = 1, parity_count = 1, single one-cycle error_pulse.
- Reset asserted during RX_WAIT of the 3rd continuous frame -> next cycle state IDLE, start_tx = 0, all counters 0; a later start with mode 2, seed 01 sends 01, 02, 04.

Source files
------------

// File: rtl/uart_link_tester.sv
// Pattern-driven UART loopback exerciser: sends one word per frame through uart_tx, checks the
// word returned by uart_rx, and keeps saturating error/frame statistics.
module uart_link_tester #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           COUNT_WIDTH = 16,
  parameter int unsigned           NUM_FRAMES  = 0,
  parameter int unsigned           RX_TIMEOUT  = 364,
  parameter int unsigned           GAP_CYCLES  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = DATA_WIDTH'(8'hB8)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [DATA_WIDTH-1:0]  seed_i,
  output logic [DATA_WIDTH-1:0]  data_to_tx_o,
  output logic                   start_tx_o,
  input  logic                   tx_busy_i,
  input  logic [DATA_WIDTH-1:0]  data_received_i,
  input  logic                   rx_done_i,
  input  logic                   parity_error_i,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   error_pulse_o,
  output logic [COUNT_WIDTH-1:0] frame_count_o,
  output logic [COUNT_WIDTH-1:0] error_count_o,
  output logic [COUNT_WIDTH-1:0] parity_count_o,
  output logic [COUNT_WIDTH-1:0] timeout_count_o
);

  localparam int unsigned TMO_W = $clog2(RX_TIMEOUT + 2);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(RX_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] FRAME_LIMIT = COUNT_WIDTH'(NUM_FRAMES);
  localparam bit FRAMES_BOUNDED = (NUM_FRAMES != 0);

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_START = 3'd1,
    S_TX_WAIT  = 3'd2,
    S_RX_WAIT  = 3'd3,
    S_CHECK    = 3'd4,
    S_UPDATE   = 3'd5,
    S_GAP      = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] next_pattern(input logic [1:0] m,
                                                        input logic [DATA_WIDTH-1:0] p);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      MODE_INC:  r = p + DATA_WIDTH'(1);
      MODE_PRBS: r = (p >> 1) ^ (p[0] ? LFSR_TAPS : {DATA_WIDTH{1'b0}});
      MODE_WALK: r = {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      default:   r = p;
    endcase
    return r;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == {COUNT_WIDTH{1'b1}}) ? c : c + COUNT_WIDTH'(1);
  endfunction

  state_t                 state_q;
  logic [1:0]             mode_q;
  logic [DATA_WIDTH-1:0]  data_to_tx_q;
  logic                   start_tx_q;
  logic                   running_q;
  logic                   done_q;
  logic                   error_pulse_q;
  logic [COUNT_WIDTH-1:0] frame_count_q;
  logic [COUNT_WIDTH-1:0] error_count_q;
  logic [COUNT_WIDTH-1:0] parity_count_q;
  logic [COUNT_WIDTH-1:0] timeout_count_q;
  logic                   rx_seen_q;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_parity_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [GAP_W-1:0]       gap_q;

  logic [DATA_WIDTH-1:0]  seed_d;
  logic [DATA_WIDTH-1:0]  pattern_d;
  logic [COUNT_WIDTH-1:0] frame_inc_d;
  logic [TMO_W-1:0]       tmo_inc_d;
  logic                   in_window_d;
  logic                   mismatch_d;

  // Derived next values shared by several FSM branches.
  always_comb begin
    seed_d      = seed_i;
    pattern_d   = next_pattern(mode_q, data_to_tx_q);
    frame_inc_d = sat_inc(frame_count_q);
    tmo_inc_d   = tmo_q + TMO_W'(1);
    in_window_d = (state_q == S_TX_START) || (state_q == S_TX_WAIT) || (state_q == S_RX_WAIT);
    mismatch_d  = (rx_data_q != data_to_tx_q);
    if ((mode_i == MODE_PRBS) && (seed_i == {DATA_WIDTH{1'b0}})) begin
      seed_d = DATA_WIDTH'(1);
    end else begin
      seed_d = seed_i;
    end
  end

  // Frame sequencer, rx capture and statistics.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      mode_q          <= 2'd0;
      data_to_tx_q    <= {DATA_WIDTH{1'b0}};
      start_tx_q      <= 1'b0;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      error_pulse_q   <= 1'b0;
      frame_count_q   <= {COUNT_WIDTH{1'b0}};
      error_count_q   <= {COUNT_WIDTH{1'b0}};
      parity_count_q  <= {COUNT_WIDTH{1'b0}};
      timeout_count_q <= {COUNT_WIDTH{1'b0}};
      rx_seen_q       <= 1'b0;
      rx_data_q       <= {DATA_WIDTH{1'b0}};
      rx_parity_q     <= 1'b0;
      tmo_q           <= {TMO_W{1'b0}};
      gap_q           <= {GAP_W{1'b0}};
    end else begin
      error_pulse_q <= 1'b0;
      // rx_done may legitimately land while tx_busy is still high, so capture spans the whole frame.
      if (in_window_d && rx_done_i) begin
        rx_seen_q   <= 1'b1;
        rx_data_q   <= data_received_i;
        rx_parity_q <= parity_error_i;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q          <= mode_i;
            data_to_tx_q    <= seed_d;
            frame_count_q   <= {COUNT_WIDTH{1'b0}};
            error_count_q   <= {COUNT_WIDTH{1'b0}};
            parity_count_q  <= {COUNT_WIDTH{1'b0}};
            timeout_count_q <= {COUNT_WIDTH{1'b0}};
            done_q          <= 1'b0;
            running_q       <= 1'b1;
            start_tx_q      <= 1'b1;
            rx_seen_q       <= 1'b0;
            state_q         <= S_TX_START;
          end
        end
        S_TX_START: begin
          if (tx_busy_i) begin
            start_tx_q <= 1'b0;
            state_q    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (!tx_busy_i) begin
            tmo_q   <= {TMO_W{1'b0}};
            state_q <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (rx_seen_q) begin
            state_q <= S_CHECK;
          end else begin
            tmo_q <= tmo_inc_d;
            if (tmo_inc_d >= TMO_LIMIT) begin
              timeout_count_q <= sat_inc(timeout_count_q);
              error_pulse_q   <= 1'b1;
              state_q         <= S_UPDATE;
            end
          end
        end
        S_CHECK: begin
          if (mismatch_d) begin
            error_count_q <= sat_inc(error_count_q);
          end
          if (rx_parity_q) begin
            parity_count_q <= sat_inc(parity_count_q);
          end
          error_pulse_q <= mismatch_d | rx_parity_q;
          state_q       <= S_UPDATE;
        end
        S_UPDATE: begin
          frame_count_q <= frame_inc_d;
          data_to_tx_q  <= pattern_d;
          if (FRAMES_BOUNDED && (frame_inc_d == FRAME_LIMIT)) begin
            running_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (GAP_CYCLES == 0) begin
            start_tx_q <= 1'b1;
            rx_seen_q  <= 1'b0;
            state_q    <= S_TX_START;
          end else begin
            gap_q   <= {GAP_W{1'b0}};
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            start_tx_q <= 1'b1;
            rx_seen_q  <= 1'b0;
            state_q    <= S_TX_START;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_to_tx_o    = data_to_tx_q;
  assign start_tx_o      = start_tx_q;
  assign running_o       = running_q;
  assign done_o          = done_q;
  assign error_pulse_o   = error_pulse_q;
  assign frame_count_o   = frame_count_q;
  assign error_count_o   = error_count_q;
  assign parity_count_o  = parity_count_q;
  assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_uart_link_tester.sv
// Bench for uart_link_tester: a behavioural loopback UART answers each transmit request and a
// pattern reference model predicts every transmitted word and every statistic.
`timescale 1ns/1ps
module tb_uart_link_tester;
  localparam int NF     = 4;
  localparam int RXT    = 10;
  localparam int GAPC   = 3;
  localparam int TX_LEN = 6;
  localparam int RX_LAT = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  seed_i = 8'd0;
  logic [7:0]  data_to_tx_o;
  logic        start_tx_o;
  logic        tx_busy_i = 1'b0;
  logic [7:0]  data_received_i = 8'd0;
  logic        rx_done_i = 1'b0;
  logic        parity_error_i = 1'b0;
  logic        running_o, done_o, error_pulse_o;
  logic [15:0] frame_count_o, error_count_o, parity_count_o, timeout_count_o;

  uart_link_tester #(
    .DATA_WIDTH(8), .COUNT_WIDTH(16), .NUM_FRAMES(NF), .RX_TIMEOUT(RXT),
    .GAP_CYCLES(GAPC), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
    .data_to_tx_o(data_to_tx_o), .start_tx_o(start_tx_o), .tx_busy_i(tx_busy_i),
    .data_received_i(data_received_i), .rx_done_i(rx_done_i), .parity_error_i(parity_error_i),
    .running_o(running_o), .done_o(done_o), .error_pulse_o(error_pulse_o),
    .frame_count_o(frame_count_o), .error_count_o(error_count_o),
    .parity_count_o(parity_count_o), .timeout_count_o(timeout_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit echo_en = 1'b1;
  bit early_rx = 1'b0;
  int corrupt_frame = 0;
  int parity_frame = 0;
  int run_base = 0;
  logic [7:0] sent_q[$];
  int fall_cyc_q[$];
  int pulse_cyc_q[$];
  int pulse_hi = 0;
  logic pulse_prev = 1'b0;
  logic [7:0] m_word;
  int m_idx;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [7:0] rx_word(input int idx, input logic [7:0] w);
    return (idx == corrupt_frame) ? (w ^ 8'h01) : w;
  endfunction

  // Loopback UART: busy for TX_LEN cycles per request, then echoes the word (optionally damaged).
  always begin
    @(negedge clk_i);
    if (!reset_i && start_tx_o === 1'b1 && !tx_busy_i) begin
      m_word = data_to_tx_o;
      sent_q.push_back(m_word);
      m_idx = sent_q.size() - run_base;
      tx_busy_i = 1'b1;
      repeat (TX_LEN - 1) @(negedge clk_i);
      if (echo_en && early_rx) begin
        rx_done_i = 1'b1;
        data_received_i = rx_word(m_idx, m_word);
        parity_error_i = (m_idx == parity_frame);
      end
      @(negedge clk_i);
      rx_done_i = 1'b0;
      parity_error_i = 1'b0;
      tx_busy_i = 1'b0;
      fall_cyc_q.push_back(cyc);
      if (echo_en && !early_rx) begin
        repeat (RX_LAT) @(negedge clk_i);
        rx_done_i = 1'b1;
        data_received_i = rx_word(m_idx, m_word);
        parity_error_i = (m_idx == parity_frame);
        @(negedge clk_i);
        rx_done_i = 1'b0;
        parity_error_i = 1'b0;
      end
    end
  end

  // Count error_pulse high cycles and note the cycle each pulse begins.
  always @(negedge clk_i) begin
    if (error_pulse_o === 1'b1) begin
      pulse_hi <= pulse_hi + 1;
      if (pulse_prev !== 1'b1) pulse_cyc_q.push_back(cyc);
    end
    pulse_prev <= error_pulse_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pattern rules written as plain arithmetic on an integer word.
  function automatic logic [7:0] ref_next(input logic [1:0] m, input logic [7:0] p);
    int v;
    v = int'(p);
    case (m)
      2'd0:    v = (v + 1) % 256;
      2'd1:    v = (v % 2 == 1) ? ((v / 2) ^ 32'hB8) : (v / 2);
      2'd2:    v = (v * 2) % 256 + v / 128;
      default: v = v;
    endcase
    return v[7:0];
  endfunction

  task automatic run_frames(input string tag, input logic [1:0] m, input logic [7:0] s,
                            input bit echo, input bit early, input int cf, input int pf,
                            input bit poke_start);
    logic [7:0] exp_w;
    int base, pbase, hbase, fbase;
    int exp_err, exp_par, exp_tmo, exp_pulse;
    bit fin;
    echo_en = echo; early_rx = early; corrupt_frame = cf; parity_frame = pf;
    base = sent_q.size(); run_base = base;
    pbase = pulse_cyc_q.size(); hbase = pulse_hi; fbase = fall_cyc_q.size();
    @(negedge clk_i);
    start_i = 1'b1; mode_i = m; seed_i = s;
    @(negedge clk_i);
    start_i = 1'b0; mode_i = 2'($urandom); seed_i = 8'($urandom);
    check($sformatf("%s.running", tag), 32'(running_o), 32'd1);
    check($sformatf("%s.done_clr", tag), 32'(done_o), 32'd0);
    if (poke_start) begin
      repeat (15) @(negedge clk_i);
      start_i = 1'b1; seed_i = 8'($urandom);
      @(negedge clk_i);
      start_i = 1'b0;
    end
    fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk_i);
      fin = (done_o === 1'b1);
    end
    check($sformatf("%s.finished", tag), 32'(fin), 32'd1);
    exp_w = (m == 2'd1 && s == 8'd0) ? 8'd1 : s;
    exp_err = 0; exp_par = 0; exp_tmo = 0; exp_pulse = 0;
    check($sformatf("%s.nsent", tag), 32'(sent_q.size() - base), 32'(NF));
    for (int i = 1; i <= NF; i++) begin
      check($sformatf("%s.word%0d", tag, i),
            (base + i - 1 < sent_q.size()) ? 32'(sent_q[base + i - 1]) : 32'hDEAD, 32'(exp_w));
      if (!echo) begin
        exp_tmo++; exp_pulse++;
      end else begin
        if (i == cf) exp_err++;
        if (i == pf) exp_par++;
        if (i == cf || i == pf) exp_pulse++;
      end
      exp_w = ref_next(m, exp_w);
    end
    check($sformatf("%s.frames", tag), 32'(frame_count_o), 32'(NF));
    check($sformatf("%s.errs", tag), 32'(error_count_o), 32'(exp_err));
    check($sformatf("%s.parity", tag), 32'(parity_count_o), 32'(exp_par));
    check($sformatf("%s.timeouts", tag), 32'(timeout_count_o), 32'(exp_tmo));
    check($sformatf("%s.done", tag), 32'(done_o), 32'd1);
    check($sformatf("%s.run_end", tag), 32'(running_o), 32'd0);
    check($sformatf("%s.pulses", tag), 32'(pulse_cyc_q.size() - pbase), 32'(exp_pulse));
    check($sformatf("%s.pulse_cycles", tag), 32'(pulse_hi - hbase), 32'(exp_pulse));
    if (!echo) begin
      // tx_busy drops mid-cycle; the DUT sees it at the next edge and fires RX_TIMEOUT edges later.
      for (int k = 0; k < NF; k++) begin
        check($sformatf("%s.tmo_delay%0d", tag, k),
              (pbase + k < pulse_cyc_q.size() && fbase + k < fall_cyc_q.size())
                ? 32'(pulse_cyc_q[pbase + k] - fall_cyc_q[fbase + k]) : 32'hDEAD,
              32'(RXT + 1));
      end
    end
  endtask

  initial begin
    int base;
    bit ok;
    repeat (3) @(negedge clk_i);
    check("rst.start_tx", 32'(start_tx_o), 32'd0);
    check("rst.running", 32'(running_o), 32'd0);
    check("rst.done", 32'(done_o), 32'd0);
    check("rst.pulse", 32'(error_pulse_o), 32'd0);
    check("rst.data", 32'(data_to_tx_o), 32'd0);
    check("rst.counters", {frame_count_o | error_count_o, parity_count_o | timeout_count_o}, 32'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    run_frames("inc", 2'd0, 8'hFE, 1'b1, 1'b0, 0, 0, 1'b0);
    run_frames("prbs0", 2'd1, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    run_frames("corrupt", 2'd0, 8'($urandom), 1'b1, 1'b0, 2, 0, 1'b0);
    run_frames("silent", 2'd3, 8'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);
    run_frames("err_par", 2'd2, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 1, 1, 1'b0);
    run_frames("early", 2'd1, 8'($urandom), 1'b1, 1'b1, 0, 3, 1'b1);

    // Reset while the third frame waits for an rx that never comes.
    echo_en = 1'b0; early_rx = 1'b0;
    base = sent_q.size(); run_base = base;
    @(negedge clk_i);
    start_i = 1'b1; mode_i = 2'd0; seed_i = 8'($urandom);
    @(negedge clk_i);
    start_i = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk_i);
      ok = (sent_q.size() - base == 3) && (tx_busy_i == 1'b0);
    end
    check("abort.reached_frame3", 32'(ok), 32'd1);
    repeat (3) @(negedge clk_i);
    check("abort.frames_before", 32'(frame_count_o), 32'd2);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("abort.start_tx", 32'(start_tx_o), 32'd0);
    check("abort.running", 32'(running_o), 32'd0);
    check("abort.counters", {frame_count_o | error_count_o, parity_count_o | timeout_count_o}, 32'd0);
    check("abort.data", 32'(data_to_tx_o), 32'd0);
    reset_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("abort.no_more_tx", 32'(sent_q.size() - base), 32'd3);
    check("abort.idle", 32'({running_o, done_o, start_tx_o}), 32'd0);
    run_frames("walk", 2'd2, 8'h01, 1'b1, 1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
